// File: rtl/gecko_fetch_predict.sv
// gecko_fetch_predict
//   Fetch stage with next-PC prediction. Holds the fetch PC and issues one
//   instruction-memory read plus one decode command per accepted PC.
//   A direct-mapped branch target table (tag, target, kind, saturating
//   counter) and a small circular return-address stack predict the next PC.
//   Execute-stage jump feedback trains the table and may redirect fetch.
//
// Ports
//   clk, rst                     clock, asynchronous active-low reset
//   jump_command_*_i             resolved branch/jump feedback (ready tied 1)
//   jump_is_call_i/_return_i     feedback sideband: call / return classification
//   table_flush_i                invalidate every table entry (fence.i)
//   instr_cmd_*                  fetched-PC metadata stream to decode
//   instr_req_*                  instruction memory read request
module gecko_fetch_predict #(
   parameter logic [31:0] START_ADDR        = '0,
   parameter int          BRANCH_ADDR_WIDTH = 7,
   parameter int          COUNTER_WIDTH     = 2,
   parameter int          RAS_DEPTH         = 4
) (
   input  logic        clk,
   input  logic        rst,
   // jump feedback
   input  logic        jump_command_valid_i,
   output logic        jump_command_ready_o,
   input  logic        jump_update_pc_i,
   input  logic [31:0] jump_current_pc_i,
   input  logic [31:0] jump_actual_next_pc_i,
   input  logic        jump_branched_i,
   input  logic        jump_jumped_i,
   input  logic        jump_miss_i,
   input  logic [7:0]  jump_history_i,
   input  logic        jump_is_call_i,
   input  logic        jump_is_return_i,
   input  logic        table_flush_i,
   // decode command
   output logic        instr_cmd_valid_o,
   input  logic        instr_cmd_ready_i,
   output logic [31:0] instr_cmd_pc_o,
   output logic [31:0] instr_cmd_next_pc_o,
   output logic [3:0]  instr_cmd_jump_flag_o,
   output logic        instr_cmd_pred_miss_o,
   output logic [7:0]  instr_cmd_pred_history_o,
   // instruction memory
   output logic        instr_req_valid_o,
   input  logic        instr_req_ready_i,
   output logic        instr_req_read_enable_o,
   output logic [3:0]  instr_req_write_enable_o,
   output logic [31:0] instr_req_data_o,
   output logic [31:0] instr_req_addr_o
);
   localparam int HIST_W  = 8;
   localparam int ENTRIES = 1 << BRANCH_ADDR_WIDTH;
   localparam int TAG_W   = 30 - BRANCH_ADDR_WIDTH;
   localparam int RAS_AW  = $clog2(RAS_DEPTH);

   localparam logic [1:0] K_BRANCH = 2'd0;
   localparam logic [1:0] K_JUMP   = 2'd1;
   localparam logic [1:0] K_CALL   = 2'd2;
   localparam logic [1:0] K_RETURN = 2'd3;

   localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);
   localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [COUNTER_WIDTH-1:0] CNT_TAKE = COUNTER_WIDTH'(1 << (COUNTER_WIDTH-1));
   localparam logic [COUNTER_WIDTH-1:0] CNT_WEAK = COUNTER_WIDTH'((1 << (COUNTER_WIDTH-1)) - 1);
   localparam logic [RAS_AW-1:0]        PTR_ONE  = RAS_AW'(1);
   localparam logic [RAS_AW:0]          RCNT_ONE = (RAS_AW+1)'(1);
   localparam logic [RAS_AW:0]          RAS_FULL = (RAS_AW+1)'(RAS_DEPTH);

   // fetch state
   logic [31:0]              pc_q, next_pc_q, pc_d, pred_next;
   logic [3:0]               jflag_q;
   logic                     active_q, cmd_pend_q, req_pend_q;
   logic                     pred_hit_q, pred_push_q, pred_pop_q;
   logic [COUNTER_WIDTH-1:0] pred_cnt_q;

   // branch target table
   logic [ENTRIES-1:0]       tbl_valid_q;
   logic [TAG_W-1:0]         tbl_tag_q  [ENTRIES];
   logic [31:0]              tbl_tgt_q  [ENTRIES];
   logic [1:0]               tbl_kind_q [ENTRIES];
   logic [COUNTER_WIDTH-1:0] tbl_cnt_q  [ENTRIES];

   // return address stack; ras_ptr_q points at the top entry
   logic [31:0]              ras_q [RAS_DEPTH];
   logic [RAS_AW-1:0]        ras_ptr_q, ras_ptr_d;
   logic [RAS_AW:0]          ras_cnt_q, ras_cnt_d;
   logic [31:0]              ras_top_d;

   logic redirect, advance, load, do_push, do_pop;

   assign redirect = jump_command_valid_i & jump_update_pc_i;
   // an output whose handshake already happened no longer blocks the advance
   assign advance  = active_q & (~cmd_pend_q | instr_cmd_ready_i)
                              & (~req_pend_q | instr_req_ready_i) & ~redirect;
   assign load     = redirect | advance | ~active_q;
   assign pc_d     = redirect ? jump_actual_next_pc_i : (advance ? next_pc_q : pc_q);
   assign do_push  = advance & pred_push_q;
   assign do_pop   = advance & pred_pop_q & (ras_cnt_q != '0);

   // RAS state after this cycle's push/pop/flush; the lookup below predicts
   // the PC being loaded, so it must see the stack as it will be.
   always_comb begin
      ras_ptr_d = ras_ptr_q;
      ras_cnt_d = ras_cnt_q;
      if (redirect) begin
         ras_cnt_d = '0;
      end else if (do_push) begin
         ras_ptr_d = ras_ptr_q + PTR_ONE;
         if (ras_cnt_q != RAS_FULL) ras_cnt_d = ras_cnt_q + RCNT_ONE;
      end else if (do_pop) begin
         ras_ptr_d = ras_ptr_q - PTR_ONE;
         ras_cnt_d = ras_cnt_q - RCNT_ONE;
      end
   end
   assign ras_top_d = do_push ? (pc_q + 32'd4) : ras_q[ras_ptr_d];

   // Lookup on the PC about to be presented. The prediction is captured into
   // registers together with that PC so next_pc leaves the block from a flop.
   logic [BRANCH_ADDR_WIDTH-1:0] lk_idx;
   logic                         lk_hit;
   logic [1:0]                   lk_kind;
   logic [COUNTER_WIDTH-1:0]     lk_cnt;
   logic [31:0]                  lk_tgt;

   assign lk_idx  = pc_d[BRANCH_ADDR_WIDTH+1:2];
   assign lk_hit  = tbl_valid_q[lk_idx] && (tbl_tag_q[lk_idx] == pc_d[31:BRANCH_ADDR_WIDTH+2]);
   assign lk_kind = tbl_kind_q[lk_idx];
   assign lk_cnt  = tbl_cnt_q[lk_idx];
   assign lk_tgt  = tbl_tgt_q[lk_idx];

   always_comb begin
      pred_next = pc_d + 32'd4;
      if (lk_hit) begin
         case (lk_kind)
            K_BRANCH: if (lk_cnt[COUNTER_WIDTH-1]) pred_next = lk_tgt;
            K_JUMP:   pred_next = lk_tgt;
            K_CALL:   pred_next = lk_tgt;
            default:  pred_next = (ras_cnt_d != '0) ? ras_top_d : lk_tgt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q        <= START_ADDR;
         next_pc_q   <= START_ADDR + 32'd4;
         jflag_q     <= '0;
         active_q    <= 1'b0;
         cmd_pend_q  <= 1'b0;
         req_pend_q  <= 1'b0;
         pred_hit_q  <= 1'b0;
         pred_cnt_q  <= '0;
         pred_push_q <= 1'b0;
         pred_pop_q  <= 1'b0;
         ras_ptr_q   <= '0;
         ras_cnt_q   <= '0;
      end else begin
         active_q  <= 1'b1;
         ras_ptr_q <= ras_ptr_d;
         ras_cnt_q <= ras_cnt_d;
         if (redirect) jflag_q <= jflag_q + 4'd1;
         if (load) begin
            pc_q        <= pc_d;
            next_pc_q   <= pred_next;
            pred_hit_q  <= lk_hit;
            pred_cnt_q  <= lk_hit ? lk_cnt : '0;
            pred_push_q <= lk_hit && (lk_kind == K_CALL);
            pred_pop_q  <= lk_hit && (lk_kind == K_RETURN);
            cmd_pend_q  <= 1'b1;
            req_pend_q  <= 1'b1;
         end else begin
            cmd_pend_q  <= cmd_pend_q & ~instr_cmd_ready_i;
            req_pend_q  <= req_pend_q & ~instr_req_ready_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) ras_q[ras_ptr_d] <= pc_q + 32'd4;
   end

   // table training from resolved jumps
   logic [BRANCH_ADDR_WIDTH-1:0] w_idx;
   logic [COUNTER_WIDTH-1:0]     w_hist, w_cnt;
   logic [1:0]                   w_kind;

   assign w_idx  = jump_current_pc_i[BRANCH_ADDR_WIDTH+1:2];
   assign w_hist = jump_history_i[COUNTER_WIDTH-1:0];

   always_comb begin
      if (jump_miss_i)          w_cnt = jump_branched_i ? CNT_TAKE : CNT_WEAK;
      else if (jump_branched_i) w_cnt = (w_hist == CNT_MAX) ? w_hist : w_hist + CNT_ONE;
      else                      w_cnt = (w_hist == '0) ? w_hist : w_hist - CNT_ONE;
      if (jump_is_return_i)     w_kind = K_RETURN;
      else if (jump_is_call_i)  w_kind = K_CALL;
      else if (jump_jumped_i)   w_kind = K_JUMP;
      else                      w_kind = K_BRANCH;
   end

   // flush beats a coincident write so the written entry stays invalid
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                      tbl_valid_q <= '0;
      else if (table_flush_i)        tbl_valid_q <= '0;
      else if (jump_command_valid_i) tbl_valid_q[w_idx] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (jump_command_valid_i) begin
         tbl_tag_q[w_idx]  <= jump_current_pc_i[31:BRANCH_ADDR_WIDTH+2];
         tbl_tgt_q[w_idx]  <= jump_actual_next_pc_i;
         tbl_kind_q[w_idx] <= w_kind;
         tbl_cnt_q[w_idx]  <= w_cnt;
      end
   end

   logic unused_bits;
   assign unused_bits = ^{jump_history_i, jump_current_pc_i[1:0]};

   assign jump_command_ready_o     = 1'b1;
   assign instr_cmd_valid_o        = cmd_pend_q;
   assign instr_cmd_pc_o           = pc_q;
   assign instr_cmd_next_pc_o      = next_pc_q;
   assign instr_cmd_jump_flag_o    = jflag_q;
   assign instr_cmd_pred_miss_o    = ~pred_hit_q;
   assign instr_cmd_pred_history_o = HIST_W'(pred_cnt_q);
   assign instr_req_valid_o        = req_pend_q;
   assign instr_req_read_enable_o  = 1'b1;
   assign instr_req_write_enable_o = '0;
   assign instr_req_data_o         = '0;
   assign instr_req_addr_o         = pc_q;
endmodule

// File: tb/tb_gecko_fetch_predict.sv
// Directed bench for gecko_fetch_predict (START 0x100, 3-bit counters,
// 2-entry RAS). Inputs change and outputs are sampled 1ns after posedge.
module tb_gecko_fetch_predict;
   logic        clk = 1'b0;
   logic        rst;
   logic        jc_valid, jc_ready, jc_update, jc_branched, jc_jumped, jc_miss;
   logic [31:0] jc_cur, jc_next;
   logic [7:0]  jc_hist;
   logic        is_call, is_ret, flush;
   logic        cmd_valid, cmd_ready, cmd_miss;
   logic [31:0] cmd_pc, cmd_next;
   logic [3:0]  cmd_jf;
   logic [7:0]  cmd_hist;
   logic        req_valid, req_ready, req_re;
   logic [3:0]  req_we;
   logic [31:0] req_data, req_addr;

   int n_chk = 0;
   int n_err = 0;
   logic [3:0] jf = 4'd0;

   gecko_fetch_predict #(
      .START_ADDR(32'h100), .BRANCH_ADDR_WIDTH(7), .COUNTER_WIDTH(3), .RAS_DEPTH(2)
   ) dut (
      .clk(clk), .rst(rst),
      .jump_command_valid_i(jc_valid), .jump_command_ready_o(jc_ready),
      .jump_update_pc_i(jc_update), .jump_current_pc_i(jc_cur),
      .jump_actual_next_pc_i(jc_next), .jump_branched_i(jc_branched),
      .jump_jumped_i(jc_jumped), .jump_miss_i(jc_miss), .jump_history_i(jc_hist),
      .jump_is_call_i(is_call), .jump_is_return_i(is_ret), .table_flush_i(flush),
      .instr_cmd_valid_o(cmd_valid), .instr_cmd_ready_i(cmd_ready),
      .instr_cmd_pc_o(cmd_pc), .instr_cmd_next_pc_o(cmd_next),
      .instr_cmd_jump_flag_o(cmd_jf), .instr_cmd_pred_miss_o(cmd_miss),
      .instr_cmd_pred_history_o(cmd_hist),
      .instr_req_valid_o(req_valid), .instr_req_ready_i(req_ready),
      .instr_req_read_enable_o(req_re), .instr_req_write_enable_o(req_we),
      .instr_req_data_o(req_data), .instr_req_addr_o(req_addr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one feedback beat without redirect (table write only)
   task automatic train(input logic [31:0] cur, input logic [31:0] nxt, input logic br,
                        input logic jmp, input logic call, input logic ret,
                        input logic miss, input logic [7:0] hist);
      jc_valid = 1'b1; jc_update = 1'b0; jc_cur = cur; jc_next = nxt;
      jc_branched = br; jc_jumped = jmp; is_call = call; is_ret = ret;
      jc_miss = miss; jc_hist = hist;
      tick();
      jc_valid = 1'b0; is_call = 1'b0; is_ret = 1'b0;
   endtask

   // redirect fetch; writes a JUMP entry for an otherwise unused pc (0x9F0)
   task automatic redirect(input logic [31:0] nxt);
      jc_valid = 1'b1; jc_update = 1'b1; jc_cur = 32'h9F0; jc_next = nxt;
      jc_branched = 1'b0; jc_jumped = 1'b1; is_call = 1'b0; is_ret = 1'b0;
      jc_miss = 1'b1; jc_hist = 8'd0;
      tick();
      jc_valid = 1'b0; jc_update = 1'b0;
      jf = jf + 4'd1;
   endtask

   task automatic expect_addr(input string tag, input logic [31:0] a);
      check(tag, req_addr, a);
   endtask

   initial begin
      rst = 1'b0; jc_valid = 1'b0; jc_update = 1'b0; jc_cur = '0; jc_next = '0;
      jc_branched = 1'b0; jc_jumped = 1'b0; jc_miss = 1'b0; jc_hist = '0;
      is_call = 1'b0; is_ret = 1'b0; flush = 1'b0; cmd_ready = 1'b1; req_ready = 1'b1;

      // reset state
      tick(); tick();
      check("rst_cmd_valid", cmd_valid, 0);
      check("rst_req_valid", req_valid, 0);
      check("rst_pc", cmd_pc, 32'h100);
      check("rst_jf", cmd_jf, 0);
      check("jc_ready", jc_ready, 1);

      // 1. sequential fetch
      rst = 1'b1;
      tick();
      check("seq_cmd_valid", cmd_valid, 1);
      check("seq_req_valid", req_valid, 1);
      expect_addr("seq_a0", 32'h100);
      check("seq_re", req_re, 1);
      check("seq_we", req_we, 0);
      check("seq_data", req_data, 0);
      check("seq_miss", cmd_miss, 1);
      check("seq_next0", cmd_next, 32'h104);
      check("seq_jf", cmd_jf, 0);
      tick(); expect_addr("seq_a1", 32'h104);
      check("seq_cmd_pc1", cmd_pc, 32'h104);
      tick(); expect_addr("seq_a2", 32'h108);

      // 2. request backpressure at 0x104
      redirect(32'h104);
      expect_addr("bp_start", 32'h104);
      check("bp_jf", cmd_jf, jf);
      req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_addr($sformatf("bp_hold%0d", i), 32'h104);
         check($sformatf("bp_cmd_done%0d", i), cmd_valid, 0);
         check($sformatf("bp_req_hold%0d", i), req_valid, 1);
      end
      req_ready = 1'b1;
      tick();
      expect_addr("bp_adv", 32'h108);
      check("bp_cmd_valid", cmd_valid, 1);

      // 3. counter training (W=3)
      train(32'h200, 32'h180, 1, 0, 0, 0, 1, 8'd0);
      redirect(32'h200);
      check("br_t_miss", cmd_miss, 0);
      check("br_t_hist", cmd_hist, 4);
      check("br_t_next", cmd_next, 32'h180);
      tick(); expect_addr("br_t_follow", 32'h180);
      train(32'h200, 32'h204, 0, 0, 0, 0, 0, 8'd4);
      train(32'h200, 32'h204, 0, 0, 0, 0, 0, 8'd3);
      redirect(32'h200);
      check("br_nt_hist", cmd_hist, 2);
      check("br_nt_next", cmd_next, 32'h204);
      check("br_nt_jf", cmd_jf, jf);

      // 4. call/return
      train(32'h300, 32'h400, 0, 1, 1, 0, 1, 8'd0);
      train(32'h410, 32'h304, 0, 1, 0, 1, 1, 8'd0);
      redirect(32'h300);
      check("call_next", cmd_next, 32'h400);
      tick(); expect_addr("call_tgt", 32'h400);
      tick(); tick(); tick(); tick();
      expect_addr("ret_site", 32'h410);
      check("ret_pred", cmd_next, 32'h304);
      tick(); expect_addr("ret_tgt", 32'h304);

      // nested calls overflow the 2-entry stack
      train(32'h400, 32'h480, 0, 1, 1, 0, 1, 8'd0);
      train(32'h480, 32'h4C0, 0, 1, 1, 0, 1, 8'd0);
      train(32'h4C0, 32'h4F0, 0, 1, 0, 1, 1, 8'd0);
      train(32'h484, 32'h4F4, 0, 1, 0, 1, 1, 8'd0);
      train(32'h404, 32'h3A0, 0, 1, 0, 1, 1, 8'd0);
      redirect(32'h300);
      expect_addr("nest_0", 32'h300);
      tick(); expect_addr("nest_c1", 32'h400);
      tick(); expect_addr("nest_c2", 32'h480);
      tick(); expect_addr("nest_c3", 32'h4C0);
      tick(); expect_addr("nest_r1", 32'h484);
      tick(); expect_addr("nest_r2", 32'h404);
      tick(); expect_addr("nest_r3_table", 32'h3A0);

      // 5. redirect beats advance from a predicted call
      train(32'h800, 32'h820, 0, 1, 0, 1, 1, 8'd0);
      redirect(32'h300);
      check("prio_pre_next", cmd_next, 32'h400);
      redirect(32'h800);
      expect_addr("prio_addr", 32'h800);
      check("prio_jf", cmd_jf, jf);
      check("prio_ras_empty", cmd_next, 32'h820);

      // 6. flush with coincident write, then async reset
      flush = 1'b1;
      train(32'h600, 32'h700, 0, 1, 0, 0, 1, 8'd0);
      flush = 1'b0;
      redirect(32'h600);
      check("flush_wr_miss", cmd_miss, 1);
      check("flush_wr_next", cmd_next, 32'h604);
      redirect(32'h300);
      check("flush_old_miss", cmd_miss, 1);
      check("flush_old_next", cmd_next, 32'h304);

      train(32'h100, 32'h180, 0, 1, 0, 0, 1, 8'd0);
      #2 rst = 1'b0;
      #1;
      check("arst_cmd_valid", cmd_valid, 0);
      check("arst_req_valid", req_valid, 0);
      check("arst_pc", req_addr, 32'h100);
      check("arst_jf", cmd_jf, 0);
      jf = 4'd0;
      tick();
      rst = 1'b1;
      tick();
      check("rst2_valid", cmd_valid, 1);
      expect_addr("rst2_a0", 32'h100);
      check("rst2_miss", cmd_miss, 1);
      check("rst2_next", cmd_next, 32'h104);
      tick(); expect_addr("rst2_a1", 32'h104);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
